// File: rtl/soc_system_actuator_out_pio.sv
//------------------------------------------------------------------------------
// Module      : soc_system_actuator_out_pio
// Description : Avalon-MM output PIO for the actuator lines. Software writes a
//               data register, atomically sets/clears bits, or fires
//               fixed-length one-shot pulses. Register map (word address):
//                 0 DATA   (RW)  data_reg
//                 1 PULSE  (W: mask fires pulse, R: {wdt_trip,busy,mask})
//                 2 OUTSET (W1S, reads 0)
//                 3 OUTCLR (W1C, reads 0)
// Options     : PIO_OUT_WDT_EN - when defined, a watchdog forces out_port to
//               SAFE_VALUE if no write arrives for WDT_CYCLES clocks.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module soc_system_actuator_out_pio #(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned RESET_VALUE  = 0,
  parameter int unsigned PULSE_CYCLES = 50000,
  parameter int unsigned SAFE_VALUE   = 0,
  parameter int unsigned WDT_CYCLES   = 50000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam int unsigned      c_cnt_w       = $clog2(PULSE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_pulse_load = c_cnt_w'(PULSE_CYCLES);
  localparam logic [WIDTH-1:0] c_reset_value = WIDTH'(RESET_VALUE);

  localparam logic [1:0] c_addr_data   = 2'd0;
  localparam logic [1:0] c_addr_pulse  = 2'd1;
  localparam logic [1:0] c_addr_outset = 2'd2;
  localparam logic [1:0] c_addr_outclr = 2'd3;

  logic [WIDTH-1:0]   r_data;
  logic [WIDTH-1:0]   r_mask;
  logic [c_cnt_w-1:0] r_cnt;

  logic [WIDTH-1:0]   w_data_nxt;
  logic [WIDTH-1:0]   w_mask_nxt;
  logic [c_cnt_w-1:0] w_cnt_nxt;

  logic               w_wr;
  logic [WIDTH-1:0]   w_wd;
  logic [31:0]        w_status;
  logic [31:0]        w_rdata;
  logic               w_trip_bit;

  // Bits of writedata above WIDTH carry no meaning for this block.
  logic               w_unused_wd;
  assign w_unused_wd = &{1'b0, writedata[31:WIDTH]};

  assign w_wr     = chipselect & ~write_n;
  assign w_wd     = writedata[WIDTH-1:0];
  assign out_port = r_data;

`ifdef PIO_OUT_WDT_EN
  localparam int unsigned        c_wdt_w    = $clog2(WDT_CYCLES + 1);
  localparam logic [c_wdt_w-1:0] c_wdt_load = c_wdt_w'(WDT_CYCLES);
  localparam logic [WIDTH-1:0]   c_safe     = WIDTH'(SAFE_VALUE);

  logic [c_wdt_w-1:0] r_wdt_cnt;
  logic               r_wdt_trip;
  logic               w_wdt_fire;

  // The watchdog fires on the 1->0 step of its counter; a write in that
  // same cycle reloads it instead, so the write wins.
  assign w_wdt_fire = (r_wdt_cnt == c_wdt_w'(1)) & ~w_wr;
  assign w_trip_bit = r_wdt_trip;

  // Watchdog counter reloads on any write and parks at zero once expired.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wdt_cnt  <= c_wdt_load;
      r_wdt_trip <= 1'b0;
    end else if (w_wr) begin
      r_wdt_cnt  <= c_wdt_load;
      r_wdt_trip <= 1'b0;
    end else if (r_wdt_cnt != '0) begin
      r_wdt_cnt  <= r_wdt_cnt - c_wdt_w'(1);
      if (w_wdt_fire) begin
        r_wdt_trip <= 1'b1;
      end
    end
  end
`else
  localparam int unsigned c_unused_cfg = SAFE_VALUE + WDT_CYCLES;
  assign w_trip_bit = 1'b0;
`endif

  // Next-state of data/mask/counter: pulse expiry first, then watchdog trip,
  // then any bus write layered on top so written bits always win.
  always_comb begin
    w_data_nxt = r_data;
    w_mask_nxt = r_mask;
    w_cnt_nxt  = r_cnt;

    if (r_cnt == c_cnt_w'(1)) begin
      w_data_nxt = r_data & ~r_mask;
      w_mask_nxt = '0;
      w_cnt_nxt  = '0;
    end else if (r_cnt != '0) begin
      w_cnt_nxt  = r_cnt - c_cnt_w'(1);
    end

`ifdef PIO_OUT_WDT_EN
    if (w_wdt_fire) begin
      w_data_nxt = c_safe;
      w_mask_nxt = '0;
      w_cnt_nxt  = '0;
    end
`endif

    if (w_wr) begin
      case (address)
        c_addr_data: begin
          w_data_nxt = w_wd;
          w_mask_nxt = '0;
          w_cnt_nxt  = '0;
        end
        c_addr_pulse: begin
          if (w_wd != '0) begin
            w_data_nxt = w_data_nxt | w_wd;
            w_mask_nxt = w_mask_nxt | w_wd;
            w_cnt_nxt  = c_pulse_load;
          end
        end
        c_addr_outset: begin
          w_data_nxt = w_data_nxt | w_wd;
          w_mask_nxt = w_mask_nxt & ~w_wd;
          if (w_mask_nxt == '0) begin
            w_cnt_nxt = '0;
          end
        end
        default: begin
          w_data_nxt = w_data_nxt & ~w_wd;
          w_mask_nxt = w_mask_nxt & ~w_wd;
          if (w_mask_nxt == '0) begin
            w_cnt_nxt = '0;
          end
        end
      endcase
    end
  end

  // Output data, pulse mask and pulse counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= c_reset_value;
      r_mask <= '0;
      r_cnt  <= '0;
    end else begin
      r_data <= w_data_nxt;
      r_mask <= w_mask_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  // Status word and read mux built from the current register state.
  always_comb begin
    w_status             = '0;
    w_status[WIDTH-1:0]  = r_mask;
    w_status[16]         = (r_cnt != '0);
    w_status[31]         = w_trip_bit;

    w_rdata = '0;
    case (address)
      c_addr_data:  w_rdata[WIDTH-1:0] = r_data;
      c_addr_pulse: w_rdata            = w_status;
      default:      w_rdata            = '0;
    endcase
  end

  // Read data is registered every cycle; there is no read strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= w_rdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_soc_system_actuator_out_pio.sv
//------------------------------------------------------------------------------
// Module      : tb_soc_system_actuator_out_pio
// Description : Directed self-checking bench for soc_system_actuator_out_pio.
//               Watchdog checks run only when PIO_OUT_WDT_EN is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_soc_system_actuator_out_pio;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  out_port;

  int n_total;
  int n_bad;

  soc_system_actuator_out_pio #(
    .WIDTH        (4),
    .RESET_VALUE  (5),
    .PULSE_CYCLES (5),
    .SAFE_VALUE   (0),
    .WDT_CYCLES   (20)
  ) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Write issued in the current cycle; returns at the negedge after it lands.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
  endtask

  // Address presented for one cycle; returns the registered read data.
  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got time limit expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    n_total    = 0;
    n_bad      = 0;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;

    // Reset values
    repeat (3) tick();
    chk("rst_out", {28'h0, out_port}, 32'h5);
    chk("rst_rd", readdata, 32'h0);
    reset_n = 1'b1;
    tick();
    chk("rst_hold", {28'h0, out_port}, 32'h5);

    // DATA write and readback
    wr(2'd0, 32'hA);
    chk("data_out", {28'h0, out_port}, 32'hA);
    rd(2'd0, r);
    chk("data_rd", r, 32'h0000_000A);
    wr(2'd0, 32'hFFFF_FFF9);
    chk("data_hi_ign", {28'h0, out_port}, 32'h9);
    rd(2'd0, r);
    chk("data_hi_rd", r, 32'h9);

    // OUTSET / OUTCLR
    wr(2'd0, 32'h3);
    wr(2'd2, 32'h4);
    chk("outset", {28'h0, out_port}, 32'h7);
    wr(2'd3, 32'h1);
    chk("outclr", {28'h0, out_port}, 32'h6);
    rd(2'd2, r);
    chk("rd_outset", r, 32'h0);
    rd(2'd3, r);
    chk("rd_outclr", r, 32'h0);
    rd(2'd0, r);
    chk("rd_after_sc", r, 32'h6);

    // Single pulse: write at t, high t+1..t+5, low at t+6
    wr(2'd0, 32'h0);
    wr(2'd1, 32'h8);                       // now at t+1
    chk("pulse_t1", {28'h0, out_port}, 32'h8);
    rd(2'd1, r);                           // now at t+2
    chk("pulse_status", r, 32'h0001_0008);
    chk("pulse_t2", {28'h0, out_port}, 32'h8);
    for (int i = 3; i <= 5; i++) begin
      tick();
      chk($sformatf("pulse_t%0d", i), {28'h0, out_port}, 32'h8);
    end
    tick();                                // t+6
    chk("pulse_t6_low", {28'h0, out_port}, 32'h0);
    rd(2'd1, r);
    chk("pulse_status_done", r, 32'h0);

    // Restart: pulse bit0 at t, pulse bit1 at t+3 -> both clear at t+9
    wr(2'd1, 32'h1);                       // now t+1
    tick();
    tick();                                // t+3
    wr(2'd1, 32'h2);                       // now t+4
    chk("restart_t4", {28'h0, out_port}, 32'h3);
    for (int i = 5; i <= 8; i++) begin
      tick();
      chk($sformatf("restart_t%0d", i), {28'h0, out_port}, 32'h3);
    end
    tick();                                // t+9
    chk("restart_low", {28'h0, out_port}, 32'h0);

    // OUTSET of one pulsed bit: that bit survives expiry
    wr(2'd1, 32'h3);                       // now t+1
    wr(2'd2, 32'h1);                       // now t+2
    rd(2'd1, r);                           // now t+3
    chk("set_status", r, 32'h0001_0002);
    tick();
    tick();                                // t+5
    chk("set_t5", {28'h0, out_port}, 32'h3);
    tick();                                // t+6
    chk("set_survive", {28'h0, out_port}, 32'h1);

    // OUTCLR of whole mask cancels the pulse
    wr(2'd1, 32'h4);
    chk("cancel_hi", {28'h0, out_port}, 32'h5);
    wr(2'd3, 32'h4);
    chk("cancel_out", {28'h0, out_port}, 32'h1);
    rd(2'd1, r);
    chk("cancel_status", r, 32'h0);

    // Expiry coincident with OUTSET of the pulsed bit
    wr(2'd0, 32'h0);
    wr(2'd1, 32'h2);                       // now t+1
    repeat (4) tick();                     // t+5
    wr(2'd2, 32'h2);                       // write in expiry cycle
    chk("coinc_set_out", {28'h0, out_port}, 32'h2);
    rd(2'd1, r);
    chk("coinc_set_status", r, 32'h0);
    tick();
    chk("coinc_set_hold", {28'h0, out_port}, 32'h2);

    // Expiry coincident with a new PULSE write: restarts, bits stay high
    wr(2'd1, 32'h4);                       // now t+1, out 6
    repeat (4) tick();                     // t+5
    wr(2'd1, 32'h4);                       // now t+6
    chk("coinc_pulse_out", {28'h0, out_port}, 32'h6);
    rd(2'd1, r);
    chk("coinc_pulse_status", r, 32'h0001_0004);
    repeat (3) tick();                     // t+10
    chk("coinc_pulse_t10", {28'h0, out_port}, 32'h6);
    tick();                                // t+11
    chk("coinc_pulse_low", {28'h0, out_port}, 32'h2);

    // Reset asserted mid-pulse
    wr(2'd1, 32'h8);
    chk("rst_pulse_hi", {28'h0, out_port}, 32'hA);
    #2 reset_n = 1'b0;
    #1 chk("rst_async", {28'h0, out_port}, 32'h5);
    tick();
    reset_n = 1'b1;
    repeat (7) tick();
    chk("rst_no_resume", {28'h0, out_port}, 32'h5);
    rd(2'd1, r);
    chk("rst_status", r, 32'h0);

`ifdef PIO_OUT_WDT_EN
    // Watchdog: DATA=F at t, holds through t+20, safe at t+21
    wr(2'd0, 32'hF);                       // now t+1
    repeat (19) tick();                    // t+20
    chk("wdt_hold", {28'h0, out_port}, 32'hF);
    tick();                                // t+21
    chk("wdt_safe", {28'h0, out_port}, 32'h0);
    rd(2'd1, r);
    chk("wdt_status", r, 32'h8000_0000);
    repeat (5) tick();
    chk("wdt_stay", {28'h0, out_port}, 32'h0);
    wr(2'd0, 32'h1);
    chk("wdt_recover", {28'h0, out_port}, 32'h1);
    rd(2'd1, r);
    chk("wdt_clear", r, 32'h0);
`else
    // Without the watchdog outputs hold indefinitely
    wr(2'd0, 32'hF);
    repeat (30) tick();
    chk("nowdt_hold", {28'h0, out_port}, 32'hF);
    rd(2'd1, r);
    chk("nowdt_status", r, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
